// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-network layer datapath blocks.
package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCUM  = 3'd1,
        S_DRAIN  = 3'd2,
        S_POST   = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    localparam int SAT_W = 64;
    typedef logic signed [SAT_W-1:0] wide_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Clamp a signed value into the range of a signed field of the given width.
    function automatic wide_t saturate(input wide_t value, input int width);
        wide_t hi;
        wide_t lo;
        wide_t res;
        hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (value > hi)
            res = hi;
        else if (value < lo)
            res = lo;
        else
            res = value;
        return res;
    endfunction

endpackage

// File: rtl/nn_mult_pipe.sv
// Signed DATA_W x DATA_W multiplier with MULT_STAGES pipeline registers and a
// matching valid chain; products are qualified by o_valid only.
module nn_mult_pipe
    import nn_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int MULT_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid,
    input  logic signed [DATA_W-1:0]   i_a,
    input  logic signed [DATA_W-1:0]   i_b,
    output logic                       o_valid,
    output logic signed [2*DATA_W-1:0] o_prod,
    output logic                       o_busy
);
    localparam int PROD_W = 2 * DATA_W;

    logic [MULT_STAGES-1:0]    r_vld;
    logic signed [PROD_W-1:0]  r_prod [MULT_STAGES];
    logic signed [PROD_W-1:0]  w_prod;

    assign w_prod = PROD_W'(i_a) * PROD_W'(i_b);

    // NOTE: non-blocking (<=) so every stage samples its predecessor's old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_valid;
            for (int i = 1; i < MULT_STAGES; i++)
                r_vld[i] <= r_vld[i-1];
        end
    end

    // NOTE: product registers are deliberately not reset; the valid chain guards them.
    always_ff @(posedge clk) begin
        if (i_valid)
            r_prod[0] <= w_prod;
        for (int i = 1; i < MULT_STAGES; i++)
            r_prod[i] <= r_prod[i-1];
    end

    assign o_valid = r_vld[MULT_STAGES-1];
    assign o_prod  = r_prod[MULT_STAGES-1];
    assign o_busy  = |r_vld;

endmodule

// File: rtl/neuron_mac_pipe.sv
// One neuron: streams (x, w) terms through a pipelined multiplier, accumulates a
// vector, adds bias, scales, optional ReLU, saturates and hands off the result.
module neuron_mac_pipe
    import nn_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int N_INPUTS    = 16,
    parameter int MULT_STAGES = 2,
    parameter int ACC_W       = 2 * DATA_W + clog2(N_INPUTS) + 1,
    parameter int OUT_W       = 8,
    parameter int FRAC_SHIFT  = 0,
    parameter bit RELU_EN     = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_w,
    input  logic                     in_last,
    input  logic signed [ACC_W-1:0]  bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_y,
    output logic                     out_ovf,
    output logic                     busy
);
    localparam int CNT_W = clog2(N_INPUTS + 1);
    localparam int SUM_W = ACC_W + 1;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    r_bias;
    logic                       w_accept;
    logic                       w_vec_end;
    logic                       w_handshake;
    logic                       w_prod_vld;
    logic                       w_pipe_busy;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [SUM_W-1:0]    w_sum;
    logic signed [SUM_W-1:0]    w_shifted;
    wide_t                      w_relu;

    assign in_ready    = reset && (r_state == S_IDLE || r_state == S_ACCUM);
    assign w_accept    = in_valid && in_ready;
    // The term that fills the vector ends it even without in_last.
    assign w_vec_end   = w_accept && (in_last || r_cnt == CNT_W'(N_INPUTS - 1));
    assign w_handshake = (r_state == S_OUTPUT) && out_ready;
    assign out_valid   = (r_state == S_OUTPUT);
    assign busy        = (r_state != S_IDLE);

    nn_mult_pipe #(
        .DATA_W      (DATA_W),
        .MULT_STAGES (MULT_STAGES)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_accept),
        .i_a     (in_x),
        .i_b     (in_w),
        .o_valid (w_prod_vld),
        .o_prod  (w_prod),
        .o_busy  (w_pipe_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: default assigned first so no path through this block infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_vec_end)
                    w_state_nxt = S_DRAIN;
                else if (w_accept)
                    w_state_nxt = S_ACCUM;
            end
            S_ACCUM:  if (w_vec_end)    w_state_nxt = S_DRAIN;
            S_DRAIN:  if (!w_pipe_busy) w_state_nxt = S_POST;
            S_POST:                     w_state_nxt = S_OUTPUT;
            S_OUTPUT: if (out_ready)    w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_bias <= '0;
        end else begin
            if (w_handshake) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                if (w_accept)
                    r_cnt <= r_cnt + CNT_W'(1);
                if (w_prod_vld)
                    r_acc <= r_acc + ACC_W'(w_prod);
            end
            if (w_vec_end)
                r_bias <= bias;
        end
    end

    assign w_sum     = SUM_W'(r_acc) + SUM_W'(r_bias);
    assign w_shifted = w_sum >>> FRAC_SHIFT;

    always_comb begin
        w_relu = SAT_W'(w_shifted);
        if (RELU_EN && w_relu[SAT_W-1])
            w_relu = '0;
    end

    // Overflow flags only a saturation clamp; ReLU has already been applied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_y   <= '0;
            out_ovf <= 1'b0;
        end else if (r_state == S_POST) begin
            out_y   <= OUT_W'(saturate(w_relu, OUT_W));
            out_ovf <= (saturate(w_relu, OUT_W) != w_relu);
        end
    end

endmodule
